// File: rtl/scan_frame_tx.sv
// Scan-frame serializer: buffers 16-bit distance samples and streams
// 55 AA CT FSA LSA samples (little-endian fields) over a valid/ready byte port.
module scan_frame_tx #(
    parameter int MAX_SAMPLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  s_CT,
    input  logic [15:0] s_FSA,
    input  logic [15:0] s_LSA,
    input  logic        smp_wr,
    input  logic [15:0] smp_data,
    output logic [7:0]  smp_count,
    input  logic        start,
    input  logic        tx_ready,
    output logic        tx_dv,
    output logic [7:0]  tx_byte,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam logic [7:0] MAX_CNT = 8'(MAX_SAMPLES);

    typedef enum logic [3:0] {
        S_IDLE, S_HDR0, S_HDR1, S_CT, S_FSA_L, S_FSA_H,
        S_LSA_L, S_LSA_H, S_SMP_L, S_SMP_H, S_FIN
    } state_t;

    state_t      r_state;
    logic [7:0]  r_ct;
    logic [15:0] r_fsa;
    logic [15:0] r_lsa;
    logic [7:0]  r_count;
    logic [7:0]  r_rd_idx;
    logic [15:0] r_rd_data;
    logic        r_tx_dv;
    logic [7:0]  r_tx_byte;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    // Full 8-bit address range so the look-ahead read past the last word stays in bounds.
    logic [15:0] r_mem [0:255];

    logic       w_accept;
    logic       w_start_ok;
    logic       w_wr_en;
    logic [7:0] w_rd_addr;

    assign w_accept   = r_tx_dv && tx_ready;
    assign w_start_ok = (s_CT != 8'd0) && (s_CT <= r_count);
    assign w_wr_en    = (r_state == S_IDLE) && smp_wr && !start && (r_count < MAX_CNT);
    // Fetch the next word as the current low byte is taken, so the high byte can
    // still come from r_rd_data while the following low byte is ready in time.
    assign w_rd_addr  = (r_state == S_SMP_L && w_accept) ? r_rd_idx + 8'd1 : r_rd_idx;

    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[r_count] <= smp_data;
        r_rd_data <= r_mem[w_rd_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_ct      <= 8'd0;
            r_fsa     <= 16'd0;
            r_lsa     <= 16'd0;
            r_count   <= 8'd0;
            r_rd_idx  <= 8'd0;
            r_tx_dv   <= 1'b0;
            r_tx_byte <= 8'h00;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (w_wr_en)
                r_count <= r_count + 8'd1;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_start_ok) begin
                            r_ct      <= s_CT;
                            r_fsa     <= s_FSA;
                            r_lsa     <= s_LSA;
                            r_rd_idx  <= 8'd0;
                            r_busy    <= 1'b1;
                            r_tx_dv   <= 1'b1;
                            r_tx_byte <= 8'h55;
                            r_state   <= S_HDR0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_HDR0:  if (w_accept) begin r_tx_byte <= 8'hAA;        r_state <= S_HDR1;  end
                S_HDR1:  if (w_accept) begin r_tx_byte <= r_ct;         r_state <= S_CT;    end
                S_CT:    if (w_accept) begin r_tx_byte <= r_fsa[7:0];   r_state <= S_FSA_L; end
                S_FSA_L: if (w_accept) begin r_tx_byte <= r_fsa[15:8];  r_state <= S_FSA_H; end
                S_FSA_H: if (w_accept) begin r_tx_byte <= r_lsa[7:0];   r_state <= S_LSA_L; end
                S_LSA_L: if (w_accept) begin r_tx_byte <= r_lsa[15:8];  r_state <= S_LSA_H; end
                S_LSA_H: if (w_accept) begin r_tx_byte <= r_rd_data[7:0]; r_state <= S_SMP_L; end
                S_SMP_L: begin
                    if (w_accept) begin
                        r_tx_byte <= r_rd_data[15:8];
                        r_rd_idx  <= r_rd_idx + 8'd1;
                        r_state   <= S_SMP_H;
                    end
                end
                S_SMP_H: begin
                    // r_rd_idx already points at the next word here.
                    if (w_accept) begin
                        if (r_rd_idx < r_ct) begin
                            r_tx_byte <= r_rd_data[7:0];
                            r_state   <= S_SMP_L;
                        end else begin
                            r_tx_dv <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_FIN;
                        end
                    end
                end
                S_FIN: begin
                    r_count <= 8'd0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign smp_count = r_count;
    assign tx_dv     = r_tx_dv;
    assign tx_byte   = r_tx_byte;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
endmodule

// File: tb/tb_scan_frame_tx.sv
// Randomized bench for scan_frame_tx: a queue-based model builds each expected
// frame from the buffered samples and the accepted byte stream is compared to it.
module tb_scan_frame_tx;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  s_CT;
    logic [15:0] s_FSA;
    logic [15:0] s_LSA;
    logic        smp_wr;
    logic [15:0] smp_data;
    logic [7:0]  smp_count;
    logic        start;
    logic        tx_ready;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic        busy;
    logic        done;
    logic        err;

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] mdl_buf[$];

    scan_frame_tx #(.MAX_SAMPLES(255)) dut (
        .clk(clk), .reset(reset), .s_CT(s_CT), .s_FSA(s_FSA), .s_LSA(s_LSA),
        .smp_wr(smp_wr), .smp_data(smp_data), .smp_count(smp_count),
        .start(start), .tx_ready(tx_ready), .tx_dv(tx_dv), .tx_byte(tx_byte),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [15:0] d);
        smp_wr = 1'b1;
        smp_data = d;
        step();
        smp_wr = 1'b0;
        if (mdl_buf.size() < 255)
            mdl_buf.push_back(d);
        check("smp_count_wr", 32'(smp_count), mdl_buf.size());
    endtask

    task automatic reject(input int ct, input bit with_wr);
        s_CT = 8'(ct);
        start = 1'b1;
        smp_wr = with_wr;
        smp_data = 16'(($urandom));
        step();
        start = 1'b0;
        smp_wr = 1'b0;
        check("err_pulse", 32'(err), 1);
        check("rej_dv", 32'(tx_dv), 0);
        check("rej_busy", 32'(busy), 0);
        check("rej_count", 32'(smp_count), mdl_buf.size());
        step();
        check("err_once", 32'(err), 0);
        $display("reject ct=%0d wr=%0d count=%0d", ct, with_wr, smp_count);
    endtask

    // mode 0: ready always 1, 1: pattern 1,0,0, 2: random ready
    task automatic run_frame(input int ct, input logic [15:0] fsa, input logic [15:0] lsa,
                             input int mode, input bit disturb);
        logic [7:0] exp_q[$];
        logic [7:0] prev_byte;
        bit prev_stall;
        int got;
        int cyc;
        exp_q = {8'h55, 8'hAA, 8'(ct), fsa[7:0], fsa[15:8], lsa[7:0], lsa[15:8]};
        for (int i = 0; i < ct; i++) begin
            exp_q.push_back(mdl_buf[i][7:0]);
            exp_q.push_back(mdl_buf[i][15:8]);
        end
        s_CT = 8'(ct);
        s_FSA = fsa;
        s_LSA = lsa;
        start = 1'b1;
        step();
        start = 1'b0;
        check("busy_rise", 32'(busy), 1);
        got = 0;
        cyc = 0;
        prev_stall = 1'b0;
        prev_byte = 8'h00;
        while (got < exp_q.size() && cyc < 5000) begin
            tx_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
            if (disturb && (cyc == 3 || cyc == 10)) begin
                smp_wr = 1'b1;
                smp_data = 16'($urandom);
                start = 1'b1;
                s_CT = 8'd1;
            end
            check("dv_in_frame", 32'(tx_dv), 1);
            check("no_early_done", 32'(done), 0);
            if (tx_dv) begin
                if (prev_stall)
                    check("stall_hold", 32'(tx_byte), 32'(prev_byte));
                if (tx_ready) begin
                    check($sformatf("byte%0d", got), 32'(tx_byte), 32'(exp_q[got]));
                    got++;
                end
                prev_stall = !tx_ready;
                prev_byte = tx_byte;
            end
            step();
            smp_wr = 1'b0;
            start = 1'b0;
            cyc++;
        end
        tx_ready = 1'b0;
        if (cyc >= 5000)
            check("frame_timeout", 32'(got), exp_q.size());
        if (mode == 0)
            check("back_to_back_cycles", cyc, exp_q.size());
        check("done_pulse", 32'(done), 1);
        check("dv_fall", 32'(tx_dv), 0);
        check("busy_fall", 32'(busy), 0);
        step();
        check("done_once", 32'(done), 0);
        check("count_clear", 32'(smp_count), 0);
        mdl_buf.delete();
        $display("frame ct=%0d bytes=%0d mode=%0d cycles=%0d", ct, got, mode, cyc);
    endtask

    task automatic reset_mid_frame();
        int acc;
        for (int i = 0; i < 3; i++)
            write_word(16'($urandom));
        s_CT = 8'd3;
        s_FSA = 16'h1111;
        s_LSA = 16'h2222;
        start = 1'b1;
        step();
        start = 1'b0;
        tx_ready = 1'b1;
        acc = 0;
        for (int c = 0; c < 20 && acc < 5; c++) begin
            if (tx_dv) acc++;
            step();
        end
        check("pre_reset_bytes", acc, 5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        tx_ready = 1'b0;
        mdl_buf.delete();
        check("rst_dv", 32'(tx_dv), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_count", 32'(smp_count), 0);
        check("rst_done", 32'(done), 0);
        for (int c = 0; c < 4; c++) begin
            step();
            check("rst_no_done", 32'(done), 0);
        end
        $display("reset mid-frame after %0d bytes", acc);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        s_CT = 8'd0; s_FSA = 16'd0; s_LSA = 16'd0;
        smp_wr = 1'b0; smp_data = 16'd0; start = 1'b0; tx_ready = 1'b0;
        step(); step(); step();
        reset = 1'b0;
        check("rst_tx_dv", 32'(tx_dv), 0);
        check("rst_tx_byte", 32'(tx_byte), 0);
        check("rst_busy0", 32'(busy), 0);
        check("rst_done0", 32'(done), 0);
        check("rst_err0", 32'(err), 0);
        check("rst_count0", 32'(smp_count), 0);
        step();

        write_word(16'h0064);
        write_word(16'h1234);
        run_frame(2, 16'h0A00, 16'h1400, 0, 1'b0);
        write_word(16'h0064);
        write_word(16'h1234);
        run_frame(2, 16'h0A00, 16'h1400, 1, 1'b0);

        write_word(16'($urandom));
        write_word(16'($urandom));
        reject(0, 1'b0);
        reject(3, 1'b0);
        reject(3, 1'b1);
        run_frame(2, 16'($urandom), 16'($urandom), 2, 1'b0);

        for (int i = 0; i < 256; i++)
            write_word(16'($urandom));
        check("saturate", 32'(smp_count), 255);
        run_frame(255, 16'($urandom), 16'($urandom), 0, 1'b0);

        for (int i = 0; i < 5; i++)
            write_word(16'($urandom));
        run_frame(3, 16'($urandom), 16'($urandom), 2, 1'b1);

        reset_mid_frame();
        for (int i = 0; i < 4; i++)
            write_word(16'($urandom));
        run_frame(4, 16'hBEEF, 16'hCAFE, 1, 1'b0);

        for (int f = 0; f < 8; f++) begin
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++)
                write_word(16'($urandom));
            run_frame($urandom_range(1, n), 16'($urandom), 16'($urandom),
                      $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/scan_frame_tx.md
# scan_frame_tx

Scan-frame serializer for the transmit side of the AGV UART link. Software or upstream logic loads a sample count, first/last sample angles and up to 255 16-bit distance samples. On `start`, the block emits the complete scan frame as a byte stream into the UART transmitter, with header, count, angles and samples in the exact field order and byte order the link's frame receiver parses. It sits between the sample source and the UART TX byte interface.

## Interface
- `MAX_SAMPLES`, 255: sample buffer depth in 16-bit words; the CT field is 8 bits, so 255 is the maximum.
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `s_CT` in 8: sample count for the frame; sampled on the `start` cycle.
- `s_FSA` in 16: first-sample angle; sampled on the `start` cycle.
- `s_LSA` in 16: last-sample angle; sampled on the `start` cycle.
- `smp_wr` in 1: write strobe; appends `smp_data` at buffer index `smp_count`.
- `smp_data` in 16: distance sample.
- `smp_count` out 8: number of samples currently buffered.
- `start` in 1: frame request pulse.
- `tx_ready` in 1: UART TX can accept a byte.
- `tx_dv` out 1: `tx_byte` is valid.
- `tx_byte` out 8: frame byte.
- `busy` out 1: a frame is in progress.
- `done` out 1: one-cycle pulse after the last byte is accepted.
- `err` out 1: one-cycle pulse when a `start` is rejected.

## Operation
- Frame byte order: `0x55`, `0xAA`, CT, FSA[7:0], FSA[15:8], LSA[7:0], LSA[15:8], then for i = 0..CT-1: sample[i][7:0], sample[i][15:8]. Total length is 7 + 2·CT bytes. No checksum.
- FSM states: IDLE, HDR0, HDR1, CT, FSA_L, FSA_H, LSA_L, LSA_H, SMP_L, SMP_H, FIN.
  - Each non-IDLE/FIN state presents one byte and advances only on acceptance (`tx_dv && tx_ready`).
  - SMP_H returns to SMP_L while rd_index < CT-1; otherwise it goes to FIN.
  - FIN pulses `done`, clears `smp_count` to 0, and returns to IDLE.
- Start acceptance: `start` while IDLE with 1 ≤ `s_CT` ≤ `smp_count`. The block latches CT, FSA and LSA, sets rd_index=0 and enters HDR0.
- Start rejection: `start` while IDLE with `s_CT`=0 or `s_CT` > `smp_count`. The block pulses `err` and stays IDLE. The buffer is unchanged.
- `start` while busy is ignored; no `err`.
- Writes:
  - `smp_wr` in IDLE with `smp_count` < MAX_SAMPLES stores the word and increments the count.
  - At full, the write is dropped and the count holds at 255.
  - `smp_wr` while busy is dropped.
- Samples beyond CT that are in the buffer are not sent. They are discarded when `smp_count` clears in FIN.
- `smp_wr` and `start` in the same IDLE cycle: the start check uses the pre-write `smp_count`, and the write is dropped.

## Timing
- Reset values: `tx_dv`=0, `tx_byte`=0x00, `busy`=0, `done`=0, `err`=0, `smp_count`=0, state IDLE. Buffer contents are don't-care.
- `tx_dv`, `tx_byte`, `busy`, `done` and `err` are registered outputs.
- `err` is asserted in the cycle after the rejected `start`.
- Accepted start: `busy` and `tx_dv` rise in the cycle after `start`, with `tx_byte`=0x55.
- Valid/ready rules:
  - While `tx_dv`=1 and `tx_ready`=0, `tx_byte` holds stable.
  - After an accepting cycle, the next byte is valid in the following cycle.
  - With `tx_ready` held at 1, bytes are sent back-to-back, one per cycle, with no bubbles. This includes sample boundaries, so the buffer read must be prefetched.
- Ending a frame:
  - `tx_dv` falls in the cycle after the last byte is accepted.
  - `done` pulses in the cycle after that acceptance, and `busy` falls in the same cycle.
  - A new `start` is accepted from the next cycle.
- `tx_ready` is sampled only while `tx_dv`=1.
- Reset mid-frame: in the next cycle, `tx_dv`=0, `busy`=0 and `smp_count`=0. No `done` is generated.

## Test plan
- Write 0x0064, 0x1234. Set CT=2, FSA=0x0A00, LSA=0x1400, pulse `start`, hold `tx_ready`=1. Required stream in 11 consecutive cycles: 55 AA 02 00 0A 00 14 64 00 34 12. `done` pulses once, then `smp_count`=0.
- Same frame with `tx_ready` toggling 1,0,0,1,… Required: identical byte sequence, `tx_byte` stable through every stall, no duplicated or lost bytes.
- `start` with CT=0, and separately `start` with CT=3 after only 2 writes. Required: `err` pulses one cycle after `start`, `tx_dv` stays 0, `smp_count`=2 is retained.
- Write 256 words, then `start` with CT=255. Required: `smp_count` saturates at 255 and a 517-byte frame is sent. The last two bytes are word 254, low byte then high byte.
- During a frame, pulse `smp_wr` and `start`. Required: no effect on the stream; `smp_count` is 0 after `done`.
- Assert `reset` at byte 5 of a frame. Required: `tx_dv`=0 and `busy`=0 next cycle, no `done`. A subsequent fresh load and `start` sends a correct frame.
